// File: rtl/vga_pkg.sv
// Shared types and default video geometry for the pixel fetch path.
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIX_W_DEF = 6;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-through FIFO; dout always shows the head entry.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fetch.sv
// Line prefetcher: pulls one row per active line into a FIFO under a credit limit
// and emits RGB plus syncs registered one pixel tick after the timing inputs.
module pixel_fetch
  import vga_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int CNT_W      = 11,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int X_START    = -32,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  x_i,
  input  logic [CNT_W-1:0]  y_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              underflow_o
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int SW   = CW + 1;
  localparam int WC_W = (H_RES > 1) ? $clog2(H_RES) : 1;

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] XS   = CNT_W'(X_START);
  localparam logic signed [CNT_W-1:0] HR   = CNT_W'(H_RES);
  localparam logic signed [CNT_W-1:0] VR   = CNT_W'(V_RES);
  localparam logic [WC_W-1:0]         LAST = WC_W'(H_RES - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CW-1:0]     out_q;
  logic [PIX_W-1:0]  rgb_q;
  logic              hsync_q, vsync_q, underflow_q;

  logic signed [CNT_W-1:0] x_s, y_s;
  logic              active, y_valid, line_start, credit_ok, hs;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [PIX_W-1:0]  fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic [SW-1:0]     in_flight;

  assign x_s        = x_i;
  assign y_s        = y_i;
  assign y_valid    = (y_s >= ZERO) && (y_s < VR);
  assign active     = (x_s >= ZERO) && (x_s < HR) && y_valid;
  assign line_start = enable && (x_s == XS) && y_valid;

  // Requests in flight plus buffered words never exceed the FIFO size.
  assign in_flight  = SW'(fifo_count) + SW'(out_q);
  assign credit_ok  = (in_flight < SW'(FIFO_DEPTH));
  assign hs         = mem_req && mem_ack;
  assign mem_addr   = line_base_q + ADDR_W'(word_cnt_q);

  assign fifo_push  = mem_rvalid && !fifo_full;
  assign fifo_pop   = enable && active && !fifo_empty;

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (mem_rdata),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    word_cnt_d  = word_cnt_q;
    mem_req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          state_d     = FETCH;
          word_cnt_d  = '0;
          // Rows are walked incrementally so no y*H_RES multiply is needed.
          line_base_d = (y_s == ZERO) ? '0 : line_base_q + ADDR_W'(H_RES);
        end
      end
      FETCH: begin
        mem_req = credit_ok;
        if (credit_ok && mem_ack) begin
          word_cnt_d = word_cnt_q + WC_W'(1);
          if (word_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      line_base_q <= '0;
      word_cnt_q  <= '0;
      out_q       <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      word_cnt_q  <= word_cnt_d;
      unique case ({hs, mem_rvalid})
        2'b10:   out_q <= out_q + CW'(1);
        2'b01:   out_q <= out_q - CW'(1);
        default: out_q <= out_q;
      endcase
      if (enable) begin
        hsync_q <= hsync_i;
        vsync_q <= vsync_i;
        rgb_q   <= fifo_pop ? fifo_dout : '0;
        // A starved line keeps running; late words shift the rest of it.
        if (active && fifo_empty) underflow_q <= 1'b1;
      end
    end
  end

  assign rgb_o       = rgb_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Randomized scoreboard bench for pixel_fetch on a reduced frame geometry.
module tb_pixel_fetch;

  localparam int H     = 16;
  localparam int V     = 6;
  localparam int CNT_W = 11;
  localparam int PIX_W = 6;
  localparam int DEPTH = 8;
  localparam int XS    = -10;
  localparam int AW    = 19;
  localparam int X_MIN = -12;
  localparam int X_MAX = H + 3;
  localparam int Y_MIN = -2;
  localparam int Y_MAX = V + 1;

  logic             clk = 1'b0;
  logic             reset_n, enable, hsync_i, vsync_i;
  logic [CNT_W-1:0] x_i, y_i;
  logic             mem_req, mem_ack, mem_rvalid;
  logic [AW-1:0]    mem_addr;
  logic [PIX_W-1:0] mem_rdata, rgb_o;
  logic             hsync_o, vsync_o, underflow_o;

  pixel_fetch #(
    .H_RES(H), .V_RES(V), .CNT_W(CNT_W), .PIX_W(PIX_W),
    .FIFO_DEPTH(DEPTH), .X_START(XS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .x_i(x_i), .y_i(y_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PIX_W-1:0] rgb; logic hs; logic vs; logic uf; } exp_t;
  typedef struct { logic [PIX_W-1:0] d; int due; } resp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  resp_t         resp_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_due = 0, occ = 0, div = 1;
  bit random_mem = 0, rand_sync = 0, starve = 0, uf_model = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_active(int x, int y);
    return (x >= 0) && (x < H) && (y >= 0) && (y < V);
  endfunction

  // Memory: random accept, in-order responses whose data is the low address bits.
  always @(negedge clk) begin
    int lat, xs, ys;
    resp_t r;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (reset_n && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      r = resp_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = r.d;
    end
    mem_ack = starve ? 1'b0 : (random_mem ? ($urandom_range(0, 9) < 6) : 1'b1);
    #1;
    if (reset_n) begin
      if (prev_stall && mem_req) chk("addr_hold", mem_addr, prev_addr);
      if (mem_req) chk("credit", (occ < DEPTH), 1);
      if (mem_req && mem_ack) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_req: got addr %0d expected no request", mem_addr);
        end else chk("req_addr", mem_addr, addr_q.pop_front());
        lat = random_mem ? $urandom_range(1, 6) : 1;
        r.d   = mem_addr[PIX_W-1:0];
        r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = r.due;
        resp_q.push_back(r);
        occ++;
      end
      xs = $signed(x_i);
      ys = $signed(y_i);
      if (enable && is_active(xs, ys) && !starve) occ--;
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
    end
  end

  // Output monitor: one expected entry per enable tick.
  always @(posedge clk) begin
    exp_t e;
    if (enable && reset_n) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL exp_empty: output tick with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        chk("rgb", rgb_o, e.rgb);
        chk("hsync", hsync_o, e.hs);
        chk("vsync", vsync_o, e.vs);
        chk("underflow", underflow_o, e.uf);
      end
    end
  end

  task automatic drive_tick(int x, int y);
    exp_t e;
    repeat (div - 1) begin
      @(negedge clk);
      enable = 1'b0;
    end
    @(negedge clk);
    enable  = 1'b1;
    x_i     = x[CNT_W-1:0];
    y_i     = y[CNT_W-1:0];
    hsync_i = (x == H + 1 || x == H + 2) ^ (rand_sync && $urandom_range(0, 3) == 0);
    vsync_i = (y == V + 1) ^ (rand_sync && $urandom_range(0, 7) == 0);
    if (x == XS && y >= 0 && y < V && !starve) begin
      chk("line_req_count", addr_q.size(), 0);
      for (int k = 0; k < H; k++) addr_q.push_back(AW'(y * H + k));
    end
    e.rgb = '0;
    if (is_active(x, y)) begin
      if (starve) uf_model = 1'b1;
      else        e.rgb = PIX_W'((y * H + x) & 63);
    end
    e.hs = hsync_i;
    e.vs = vsync_i;
    e.uf = uf_model;
    exp_q.push_back(e);
  endtask

  // Drive a frame, stopping right after tick (xstop, ystop).
  task automatic run_frame(int ystop, int xstop);
    for (int y = Y_MIN; y <= Y_MAX; y++)
      for (int x = X_MIN; x <= X_MAX; x++) begin
        drive_tick(x, y);
        if (y == ystop && x == xstop) return;
      end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_rgb", rgb_o, 0);
    chk("rst_hsync", hsync_o, 0);
    chk("rst_vsync", vsync_o, 0);
    chk("rst_underflow", underflow_o, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    exp_q.delete();
    addr_q.delete();
    resp_q.delete();
    occ = 0; uf_model = 0; starve = 0; prev_stall = 0;
    last_due = cyc;
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    x_i = '0; y_i = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("init_rgb", rgb_o, 0);
    chk("init_underflow", underflow_o, 0);
    chk("init_req", mem_req, 0);
    chk("init_addr", mem_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-wait memory, full-rate ticks, two frames (covers frame wrap).
    div = 1; random_mem = 0; rand_sync = 0;
    repeat (2) run_frame(Y_MAX + 1, 0);
    chk("frame_reqs_done", addr_q.size(), 0);

    // Random accept stalls and latency, random sync toggles.
    div = 4; random_mem = 1; rand_sync = 1;
    run_frame(Y_MAX + 1, 0);
    chk("frame_reqs_done_rand", addr_q.size(), 0);

    // Reset mid-line; timing restarts with the rest of the chain.
    div = 3;
    run_frame(1, 5);
    apply_reset();
    run_frame(Y_MAX + 1, 0);
    chk("frame_reqs_after_rst", addr_q.size(), 0);

    // Memory never accepts across a full active line.
    div = 1; random_mem = 0; rand_sync = 0; starve = 1;
    run_frame(1, X_MAX);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("underflow_sticky", underflow_o, 1);
    chk("exp_drained", exp_q.size(), 0);
    apply_reset();

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
